// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Fetch/execute control FSM for the PC + program-ROM datapath. Drives the
//   PC controls and the stack/scratch strobes for flow-control instructions,
//   and owns the interrupt-enable flag and the interrupt-pending latch.
//   Instructions that do not change program flow assert nothing here.
//
// Ports
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   OPCODE_HI/LO        PROG_IR[17:13] / PROG_IR[1:0], valid in EXEC
//   C_FLAG, Z_FLAG      branch condition flags
//   INT                 level interrupt request, synchronous to CLK
//   PC_RST/LD/INC       PC reset / load from mux / increment
//   PC_MUX_SEL          PC source: IMM_SEL, STK_SEL or INT_VEC_SEL
//   SP_INCR/SP_DECR     stack pointer adjust
//   SCR_WE              scratch RAM write enable
//   SCR_DATA_SEL        0 = register data, 1 = PC (return address push)
//   SCR_ADDR_SEL        00 reg, 01 immed, 10 SP, 11 SP-1
//   FLG_SHAD_LD         save C/Z into the shadow flags
//   FLG_RESTORE         restore C/Z from the shadow flags
//   I_FLAG              interrupt-enable flag (registered)
//   INT_ACK             high during the single interrupt-entry cycle
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [1:0] INT_VEC_SEL = 2'b10,
    parameter logic [1:0] STK_SEL     = 2'b01,
    parameter logic [1:0] IMM_SEL     = 2'b00
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [4:0] OPCODE_HI,
    input  logic [1:0] OPCODE_LO,
    input  logic       C_FLAG,
    input  logic       Z_FLAG,
    input  logic       INT,
    output logic       PC_RST,
    output logic       PC_LD,
    output logic       PC_INC,
    output logic [1:0] PC_MUX_SEL,
    output logic       SP_INCR,
    output logic       SP_DECR,
    output logic       SCR_WE,
    output logic       SCR_DATA_SEL,
    output logic [1:0] SCR_ADDR_SEL,
    output logic       FLG_SHAD_LD,
    output logic       FLG_RESTORE,
    output logic       I_FLAG,
    output logic       INT_ACK
);

    typedef enum logic [1:0] {
        INIT  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10,
        INTR  = 2'b11
    } state_t;

    // {OPCODE_HI, OPCODE_LO} codes of the flow-control instructions
    localparam logic [6:0] OP_BRN   = 7'b00100_00;
    localparam logic [6:0] OP_CALL  = 7'b00100_01;
    localparam logic [6:0] OP_BREQ  = 7'b00100_10;
    localparam logic [6:0] OP_BRNE  = 7'b00100_11;
    localparam logic [6:0] OP_BRCS  = 7'b00101_00;
    localparam logic [6:0] OP_BRCC  = 7'b00101_01;
    localparam logic [6:0] OP_RET   = 7'b01100_00;
    localparam logic [6:0] OP_SEI   = 7'b01101_00;
    localparam logic [6:0] OP_CLI   = 7'b01101_01;
    localparam logic [6:0] OP_RETID = 7'b01101_10;
    localparam logic [6:0] OP_RETIE = 7'b01101_11;

    state_t     state, state_next;
    logic       i_flag, i_flag_next;
    logic       int_pend, int_pend_next;
    logic [6:0] opcode;

    assign opcode = {OPCODE_HI, OPCODE_LO};
    assign I_FLAG = i_flag;

    // The asynchronous reset forces INIT immediately, so any stack write that
    // was being decoded in EXEC is withdrawn as soon as RST_N falls.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= INIT;
            i_flag   <= 1'b0;
            int_pend <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values;
            // the EXEC interrupt check relies on seeing last cycle's flags.
            state    <= state_next;
            i_flag   <= i_flag_next;
            int_pend <= int_pend_next;
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no
        // path through the case statement can infer a latch.
        state_next    = state;
        i_flag_next   = i_flag;
        int_pend_next = int_pend | INT;
        PC_RST        = 1'b0;
        PC_LD         = 1'b0;
        PC_INC        = 1'b0;
        PC_MUX_SEL    = IMM_SEL;
        SP_INCR       = 1'b0;
        SP_DECR       = 1'b0;
        SCR_WE        = 1'b0;
        SCR_DATA_SEL  = 1'b0;
        SCR_ADDR_SEL  = 2'b00;
        FLG_SHAD_LD   = 1'b0;
        FLG_RESTORE   = 1'b0;
        INT_ACK       = 1'b0;

        unique case (state)
            INIT: begin
                PC_RST     = 1'b1;
                state_next = FETCH;
            end
            FETCH: begin
                PC_INC     = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                // Uses the registered enable, so an SEI/RETIE in this very
                // instruction only arms the interrupt for the next one.
                state_next = (int_pend && i_flag) ? INTR : FETCH;
                case (opcode)
                    OP_BRN:  PC_LD = 1'b1;
                    OP_CALL: begin
                        PC_LD        = 1'b1;
                        SP_DECR      = 1'b1;
                        SCR_WE       = 1'b1;
                        SCR_DATA_SEL = 1'b1;
                        SCR_ADDR_SEL = 2'b11;
                    end
                    OP_BREQ: PC_LD = Z_FLAG;
                    OP_BRNE: PC_LD = ~Z_FLAG;
                    OP_BRCS: PC_LD = C_FLAG;
                    OP_BRCC: PC_LD = ~C_FLAG;
                    OP_RET, OP_RETID, OP_RETIE: begin
                        PC_LD        = 1'b1;
                        PC_MUX_SEL   = STK_SEL;
                        SP_INCR      = 1'b1;
                        SCR_ADDR_SEL = 2'b10;
                        if (opcode != OP_RET) begin
                            FLG_RESTORE = 1'b1;
                            i_flag_next = (opcode == OP_RETIE);
                        end
                    end
                    OP_SEI:  i_flag_next = 1'b1;
                    OP_CLI:  i_flag_next = 1'b0;
                    default: ;
                endcase
            end
            INTR: begin
                PC_LD         = 1'b1;
                PC_MUX_SEL    = INT_VEC_SEL;
                SP_DECR       = 1'b1;
                SCR_WE        = 1'b1;
                SCR_DATA_SEL  = 1'b1;
                SCR_ADDR_SEL  = 2'b11;
                FLG_SHAD_LD   = 1'b1;
                INT_ACK       = 1'b1;
                i_flag_next   = 1'b0;
                // A request held high through this cycle is picked up again
                // on the next one rather than here.
                int_pend_next = 1'b0;
                state_next    = FETCH;
            end
            default: state_next = INIT;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//   Randomised instruction stream, interrupt requests and resets (including
//   reset asserted in the middle of a CALL). A behavioural model describes
//   each cycle as "what the machine is doing" and queues the expected output
//   word; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [4:0] OPCODE_HI = '0;
    logic [1:0] OPCODE_LO = '0;
    logic       C_FLAG = 1'b0, Z_FLAG = 1'b0, INT = 1'b0;
    logic       PC_RST, PC_LD, PC_INC, SP_INCR, SP_DECR, SCR_WE, SCR_DATA_SEL;
    logic       FLG_SHAD_LD, FLG_RESTORE, I_FLAG, INT_ACK;
    logic [1:0] PC_MUX_SEL, SCR_ADDR_SEL;

    pc_sequencer dut (
        .CLK(CLK), .RST_N(RST_N), .OPCODE_HI(OPCODE_HI), .OPCODE_LO(OPCODE_LO),
        .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .INT(INT),
        .PC_RST(PC_RST), .PC_LD(PC_LD), .PC_INC(PC_INC), .PC_MUX_SEL(PC_MUX_SEL),
        .SP_INCR(SP_INCR), .SP_DECR(SP_DECR), .SCR_WE(SCR_WE),
        .SCR_DATA_SEL(SCR_DATA_SEL), .SCR_ADDR_SEL(SCR_ADDR_SEL),
        .FLG_SHAD_LD(FLG_SHAD_LD), .FLG_RESTORE(FLG_RESTORE),
        .I_FLAG(I_FLAG), .INT_ACK(INT_ACK)
    );

    always #5 CLK = ~CLK;

    // Field order of the compared output word
    typedef struct packed {
        logic       pc_rst, pc_ld, pc_inc;
        logic [1:0] mux;
        logic       sp_incr, sp_decr, scr_we, scr_data_sel;
        logic [1:0] scr_addr_sel;
        logic       flg_shad_ld, flg_restore, i_flag, int_ack;
    } outs_t;

    typedef enum int {
        K_BRN, K_CALL, K_BREQ, K_BRNE, K_BRCS, K_BRCC, K_RET,
        K_RETID, K_RETIE, K_SEI, K_CLI, K_OTHER
    } kind_t;

    // What the machine is busy with during a cycle
    typedef enum int { DO_PC_RESET, DO_FETCH, DO_EXECUTE, DO_INTERRUPT } activity_t;

    outs_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    // Model state
    activity_t act = DO_PC_RESET;
    bit        ie  = 0;
    bit        pend = 0;

    function automatic logic [6:0] code_of(kind_t k);
        case (k)
            K_BRN:   return 7'b0010000;
            K_CALL:  return 7'b0010001;
            K_BREQ:  return 7'b0010010;
            K_BRNE:  return 7'b0010011;
            K_BRCS:  return 7'b0010100;
            K_BRCC:  return 7'b0010101;
            K_RET:   return 7'b0110000;
            K_SEI:   return 7'b0110100;
            K_CLI:   return 7'b0110101;
            K_RETID: return 7'b0110110;
            K_RETIE: return 7'b0110111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic bit is_flow_code(logic [6:0] c);
        for (int k = 0; k < int'(K_OTHER); k++)
            if (code_of(kind_t'(k)) == c) return 1;
        return 0;
    endfunction

    task automatic check(string name, outs_t got, outs_t want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b required=%b", name, cyc, got, want);
        end
    endtask

    // Model: expected outputs for one cycle, and the model's view of the next
    function automatic outs_t model_step(bit rst_active, kind_t k, bit c, bit z, bit irq);
        outs_t e = '0;
        if (rst_active) begin
            e.pc_rst = 1;
            act = DO_PC_RESET; ie = 0; pend = 0;
            return e;
        end
        e.i_flag = ie;
        case (act)
            DO_PC_RESET: begin e.pc_rst = 1; pend |= irq; act = DO_FETCH; end
            DO_FETCH:    begin e.pc_inc = 1; pend |= irq; act = DO_EXECUTE; end
            DO_EXECUTE: begin
                act = (pend && ie) ? DO_INTERRUPT : DO_FETCH;
                pend |= irq;
                case (k)
                    K_BRN:  e.pc_ld = 1;
                    K_BREQ: e.pc_ld = z;
                    K_BRNE: e.pc_ld = !z;
                    K_BRCS: e.pc_ld = c;
                    K_BRCC: e.pc_ld = !c;
                    K_CALL: begin
                        e.pc_ld = 1; e.sp_decr = 1; e.scr_we = 1;
                        e.scr_data_sel = 1; e.scr_addr_sel = 2'b11;
                    end
                    K_RET, K_RETID, K_RETIE: begin
                        e.pc_ld = 1; e.mux = 2'b01; e.sp_incr = 1; e.scr_addr_sel = 2'b10;
                        if (k != K_RET) begin
                            e.flg_restore = 1;
                            ie = (k == K_RETIE);
                        end
                    end
                    K_SEI: ie = 1;
                    K_CLI: ie = 0;
                    default: ;
                endcase
            end
            DO_INTERRUPT: begin
                e.pc_ld = 1; e.mux = 2'b10; e.sp_decr = 1; e.scr_we = 1;
                e.scr_data_sel = 1; e.scr_addr_sel = 2'b11;
                e.flg_shad_ld = 1; e.int_ack = 1;
                ie = 0; pend = 0;
                act = DO_FETCH;
            end
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: compare at the falling edge, away from the active edge
    always @(negedge CLK) begin
        outs_t got, want;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {PC_RST, PC_LD, PC_INC, PC_MUX_SEL, SP_INCR, SP_DECR, SCR_WE,
                    SCR_DATA_SEL, SCR_ADDR_SEL, FLG_SHAD_LD, FLG_RESTORE, I_FLAG, INT_ACK};
            check("outs", got, want);
        end
    end

    // Stimulus
    initial begin
        int    rst_hold = 3;
        int    n_intr   = 0;
        kind_t k;
        logic [6:0] code;
        bit    mid_rst;

        for (int i = 0; i < 4000; i++) begin
            @(posedge CLK);
            #1;
            cyc = i;
            mid_rst = 0;

            // Instruction pick, biased so SEI shows up often enough to
            // exercise interrupt entry
            case ($urandom_range(0, 15))
                0: k = K_BRN;   1: k = K_CALL;  2: k = K_BREQ;  3: k = K_BRNE;
                4: k = K_BRCS;  5: k = K_BRCC;  6: k = K_RET;   7: k = K_RETID;
                8: k = K_RETIE; 9, 10: k = K_SEI; 11: k = K_CLI;
                default: k = K_OTHER;
            endcase
            if (k == K_OTHER) begin
                do code = 7'($urandom_range(0, 127)); while (is_flow_code(code));
            end else begin
                code = code_of(k);
            end
            {OPCODE_HI, OPCODE_LO} = code;
            C_FLAG = 1'($urandom_range(0, 1));
            Z_FLAG = 1'($urandom_range(0, 1));
            INT    = ($urandom_range(0, 5) == 0);

            if (rst_hold > 0) begin
                RST_N = 1'b0;
                rst_hold--;
            end else begin
                RST_N = 1'b1;
                if ($urandom_range(0, 299) == 0) begin
                    RST_N = 1'b0;
                    rst_hold = 1;
                end else if (act == DO_EXECUTE && k == K_CALL && $urandom_range(0, 3) == 0) begin
                    mid_rst = 1;
                    rst_hold = 2;
                end
            end

            if (act == DO_INTERRUPT && RST_N && !mid_rst) n_intr++;
            exp_q.push_back(model_step(!RST_N || mid_rst, k, C_FLAG, Z_FLAG, INT));

            // Reset arriving part-way through a CALL's EXEC cycle
            if (mid_rst) begin
                #2 RST_N = 1'b0;
            end
        end

        repeat (2) @(posedge CLK);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain got=%0d left required=0", exp_q.size());
        end
        if (n_intr == 0) $display("[TB] note: no interrupt entry was generated");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
